uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_cnt.sv | 66 ++++++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter, its baud counter and the
// receiver / upstream pacing logic that reuse them.
//   - state encodings for the transmit FSM
//   - DATA_BITS: payload width of one frame
//   - DEFAULT_CLKS_PER_BIT: 65 MHz / 115200 baud, also the pacing limit
//     used by the upstream lock stage
//   - cnt_width(): counter width needed to count 0..n-1
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 564;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    START = ST_START_ENC,
    DATA  = ST_DATA_ENC,
    STOP  = ST_STOP_ENC
  } tx_state_e;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0
// on the same edge the bit-end strobe is seen, so consecutive bits are
// exactly CLKS_PER_BIT cycles long.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, counter -> 0
//   clr      in   synchronous clear, has priority over en
//   en       in   count enable
//   bit_end  out  high on the last cycle of a bit period (count == N-1)
//   near_end out  high on the second-to-last cycle (count == N-2); lets a
//                 parent register a flag that lines up with the final cycle
// ----------------------------------------------------------------------------
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int unsigned CW          = cnt_width(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end,
  output logic near_end
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Strobes decoded from the registered count.
  always_comb begin
    bit_end  = en && (cnt_q == CNT_LAST);
    near_end = en && (cnt_q == CNT_NEAR);
  end

  // Next count: clear, wrap at the bit end, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// 8N1 / 8N2 serial transmitter, LSB first. One byte is captured per accepted
// tx_start (accepted only in IDLE); the frame is start bit, 8 data bits and
// STOP_BITS stop bits, each CLKS_PER_BIT cycles long. Every output is a flop,
// so the first start-bit cycle appears one cycle after acceptance.
// Ports:
//   pclk     in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (abandons any frame)
//   tx_start in   send request, only looked at while idle
//   data_in  in   byte to send, captured on the accepting cycle
//   tx       out  serial line, idle high
//   tx_busy  out  high from the cycle after acceptance to the end of frame
//   tx_done  out  one-cycle pulse on the last cycle of the final stop bit
// ----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e            state_q,   state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 tx_q,      tx_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  logic baud_clr;
  logic baud_en;
  logic bit_end;
  logic near_end;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (pclk),
    .rst_n    (rst_n),
    .clr      (baud_clr),
    .en       (baud_en),
    .bit_end  (bit_end),
    .near_end (near_end)
  );

  // The counter only runs while a frame is in flight.
  always_comb begin
    baud_en = (state_q != IDLE);
  end

  // Next-state and next-output logic. The serial line is computed for the
  // cycle after the edge, so tx always reflects state_q without a decode.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        baud_clr = 1'b1;
        if (tx_start) begin
          shift_d   = data_in;
          bit_cnt_d = 3'd0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            // Next bit to show is the one about to shift into position 0.
            tx_d      = shift_q[1];
          end
        end else begin
          state_d = DATA;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        // Registered pulse: raise it one cycle early so it is high exactly
        // on the final stop-bit cycle.
        if ((bit_cnt_q == STOP_LAST) && near_end) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        baud_clr  = 1'b1;
      end
    endcase
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
// Two transmitters with CLKS_PER_BIT=4: u_dut1 (1 stop bit) and u_dut2
// (2 stop bits). A per-cycle monitor decodes every frame on each line and
// compares it with the byte pushed to that DUT's scoreboard queue when the
// start request was driven. The main sequence adds a vector table for exact
// line patterns and hand-written sequences for the multi-cycle corners.
// ----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;

  logic       pclk;
  logic       rst_n;
  logic       tx_start1, tx_start2;
  logic [7:0] data1, data2;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .pclk(pclk), .rst_n(rst_n), .tx_start(tx_start1), .data_in(data1),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .pclk(pclk), .rst_n(rst_n), .tx_start(tx_start2), .data_in(data2),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: one queue of expected bytes per DUT.
  logic [7:0] sbq [2][$];

  // Frame monitor state, one slot per DUT.
  logic [1:0] txs, busys, dones;
  assign txs   = {tx2, tx1};
  assign busys = {busy2, busy1};
  assign dones = {done2, done1};

  bit         m_act  [2];
  int         m_cyc  [2];
  bit         m_bad  [2];
  logic [7:0] m_byte [2];
  int         stray_done = 0;

  // Decode frames at bit centres, check shape and done position, then
  // compare the byte with the scoreboard head.
  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      int last_cyc;
      int idx;
      logic [7:0] exp_b;
      last_cyc = (10 + d) * CPB - 1;
      if (!rst_n) begin
        m_act[d] = 1'b0;
      end else if (!m_act[d]) begin
        if (dones[d]) stray_done++;
        if (txs[d] === 1'b0) begin
          m_act[d]  = 1'b1;
          m_cyc[d]  = 0;
          m_bad[d]  = (busys[d] !== 1'b1);
          m_byte[d] = 8'h00;
        end
      end else begin
        m_cyc[d]++;
        if (busys[d] !== 1'b1) m_bad[d] = 1'b1;
        if (m_cyc[d] % CPB == CPB / 2) begin
          idx = m_cyc[d] / CPB;
          if (idx == 0) begin
            if (txs[d] !== 1'b0) m_bad[d] = 1'b1;
          end else if (idx <= 8) begin
            m_byte[d][idx-1] = txs[d];
          end else begin
            if (txs[d] !== 1'b1) m_bad[d] = 1'b1;
          end
        end
        if (m_cyc[d] == last_cyc) begin
          if (dones[d] !== 1'b1) m_bad[d] = 1'b1;
          if (sbq[d].size() == 0) begin
            check($sformatf("unexpected_frame_dut%0d", d + 1), 32'(m_byte[d]), 32'hFFFF_FFFF);
          end else begin
            exp_b = sbq[d].pop_front();
            check($sformatf("frame_data_dut%0d", d + 1), 32'(m_byte[d]), 32'(exp_b));
          end
          check($sformatf("frame_shape_dut%0d", d + 1), 32'(m_bad[d]), 32'd0);
          m_act[d] = 1'b0;
        end else if (dones[d]) begin
          stray_done++;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit k = line level during bit period k
  } vec_t;

  // Wait, bounded, until both scoreboards are empty and no frame is open.
  task automatic drain(input string name);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < 200 && !ok) begin
      @(negedge pclk);
      n++;
      ok = (sbq[0].size() == 0) && (sbq[1].size() == 0) && !m_act[0] && !m_act[1];
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    logic [9:0] line;
    int busy_low;
    int idle_bad;
    int len;
    int n;

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h5A, 10'b1_01011010_0};
    vecs[4] = '{8'h01, 10'b1_00000001_0};
    vecs[5] = '{8'h80, 10'b1_10000000_0};

    tx_start1 = 1'b0; tx_start2 = 1'b0;
    data1 = 8'h00; data2 = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state.
    repeat (3) @(negedge pclk);
    check("rst_tx1",   32'(tx1),   32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_tx2",   32'(tx2),   32'd1);
    check("rst_busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);

    // Vector table: exact line pattern, latency, done position, release.
    for (int v = 0; v < 6; v++) begin
      data1 = vecs[v].data;
      tx_start1 = 1'b1;
      sbq[0].push_back(vecs[v].data);
      @(negedge pclk);
      tx_start1 = 1'b0;
      check($sformatf("latency_v%0d", v), 32'({tx1, busy1}), 32'b01);
      for (int k = 0; k < 10; k++) begin
        repeat (2) @(negedge pclk);
        line[k] = tx1;
        if (k < 9) repeat (2) @(negedge pclk);
      end
      check($sformatf("line_v%0d", v), 32'(line), 32'(vecs[v].line));
      @(negedge pclk);
      check($sformatf("done_pos_v%0d", v), 32'(done1), 32'd1);
      @(negedge pclk);
      check($sformatf("release_v%0d", v), 32'({tx1, busy1, done1}), 32'b100);
    end
    drain("drain_table");

    // Ignore tx_start while busy: 3C in flight, FF requested mid-DATA.
    data1 = 8'h3C;
    tx_start1 = 1'b1;
    sbq[0].push_back(8'h3C);
    @(negedge pclk);
    tx_start1 = 1'b0;
    busy_low = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy1 !== 1'b1) busy_low++;
      if (c == 12) begin data1 = 8'hFF; tx_start1 = 1'b1; end
      if (c == 13) tx_start1 = 1'b0;
      @(negedge pclk);
    end
    check("busy_continuous", 32'(busy_low), 32'd0);
    idle_bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (tx1 !== 1'b1 || busy1 !== 1'b0) idle_bad++;
      @(negedge pclk);
    end
    check("no_second_frame", 32'(idle_bad), 32'd0);
    drain("drain_ignore");

    // Back-to-back with tx_start held high: 00 then 81.
    data1 = 8'h00;
    tx_start1 = 1'b1;
    sbq[0].push_back(8'h00);
    sbq[0].push_back(8'h81);
    @(negedge pclk);
    data1 = 8'h81;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check("b2b_done_seen", 32'(done1), 32'd1);
    @(negedge pclk);
    check("b2b_idle_gap", 32'({tx1, busy1}), 32'b10);
    @(negedge pclk);
    check("b2b_restart", 32'({tx1, busy1}), 32'b01);
    tx_start1 = 1'b0;
    drain("drain_b2b");

    // Two stop bits: 55, frame 44 cycles with done on the last one.
    data2 = 8'h55;
    tx_start2 = 1'b1;
    sbq[1].push_back(8'h55);
    @(negedge pclk);
    tx_start2 = 1'b0;
    check("stop2_latency", 32'({tx2, busy2}), 32'b01);
    len = 1;
    while (done2 !== 1'b1 && len < 100) begin
      @(negedge pclk);
      len++;
    end
    check("stop2_frame_len", 32'(len), 32'd44);
    @(negedge pclk);
    check("stop2_release", 32'({tx2, busy2, done2}), 32'b100);
    drain("drain_stop2");

    // Asynchronous reset during data bit 3 of an all-zero frame.
    data1 = 8'h00;
    tx_start1 = 1'b1;
    @(negedge pclk);
    tx_start1 = 1'b0;
    repeat (17) @(negedge pclk);
    check("pre_rst_line_low", 32'(tx1), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx1), 32'd1);
    check("async_rst_busy_done", 32'({busy1, done1}), 32'b00);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) idle_bad++;
    end
    check("post_rst_idle", 32'(idle_bad), 32'd0);
    data1 = 8'h12;
    tx_start1 = 1'b1;
    sbq[0].push_back(8'h12);
    @(negedge pclk);
    tx_start1 = 1'b0;
    drain("drain_post_rst");

    // data_in scrambled every cycle after acceptance of C3.
    data1 = 8'hC3;
    tx_start1 = 1'b1;
    sbq[0].push_back(8'hC3);
    @(negedge pclk);
    tx_start1 = 1'b0;
    for (int c = 0; c < 45; c++) begin
      data1 = 8'($urandom);
      @(negedge pclk);
    end
    drain("drain_stability");

    check("stray_done", 32'(stray_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
